// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and E-stage forwarding control for the 5-stage
// RV32I pipeline. It keeps a shadow copy of the E/M/W destination fields,
// freezes the pipeline while a data-memory access waits for its acknowledge,
// and counts stalled fetch cycles.
// Optional feature macro: HAZARD_FWD_EN
//   defined   - M/W results are forwarded into E; only load-use stalls.
//   undefined - forwards are tied to 00; any E/M producer stalls the consumer.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic        UseRs1D,
  input  logic        UseRs2D,
  input  logic [4:0]  RdD,
  input  logic        RegWEnD,
  input  logic        IsLoadD,
  input  logic        PCSelE,
  input  logic        MemReqM,
  input  logic        MemAckM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [15:0] StallCnt
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [4:0]  e_rs1_q, e_rs1_d;
  logic [4:0]  e_rs2_q, e_rs2_d;
  logic [4:0]  e_rd_q, e_rd_d;
  logic        e_regwen_q, e_regwen_d;
  logic        e_isload_q, e_isload_d;
  logic [4:0]  m_rd_q, m_rd_d;
  logic        m_regwen_q, m_regwen_d;
  logic [4:0]  w_rd_q, w_rd_d;
  logic        w_regwen_q, w_regwen_d;
  logic        redir_pend_q, redir_pend_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        mem_stall_s;
  logic        redir_s;
  logic        raw_hit_s;
  logic        stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic        flush_d_s, flush_e_s;
  logic [1:0]  fwd_a_s, fwd_b_s;

  // A used source reads a live, nonzero destination of an older instruction.
  function automatic logic src_hit(input logic use_src, input logic [4:0] rs,
                                   input logic [4:0] rd, input logic regwen);
    return use_src && regwen && (rd != 5'd0) && (rs == rd);
  endfunction

`ifdef HAZARD_FWD_EN
  // Forward select for one E source: M result beats W result; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (rs == 5'd0) begin
      return 2'b00;
    end else if (m_regwen_q && (m_rd_q == rs)) begin
      return 2'b10;
    end else if (w_regwen_q && (w_rd_q == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction
`endif

  // Memory-wait FSM: next state and whether this cycle freezes the pipeline.
  always_comb begin
    state_d     = state_q;
    mem_stall_s = 1'b0;
    case (state_q)
      RUN: begin
        if (MemReqM && !MemAckM) begin
          state_d     = MEM_WAIT;
          mem_stall_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (MemAckM) begin
          state_d = RUN;
        end else begin
          state_d     = MEM_WAIT;
          mem_stall_s = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // RAW hazard that forwarding cannot cover (load-use, or any producer without forwarding).
  always_comb begin
    raw_hit_s = 1'b0;
`ifdef HAZARD_FWD_EN
    raw_hit_s = e_isload_q &&
                (src_hit(UseRs1D, Rs1D, e_rd_q, e_regwen_q) ||
                 src_hit(UseRs2D, Rs2D, e_rd_q, e_regwen_q));
`else
    raw_hit_s = src_hit(UseRs1D, Rs1D, e_rd_q, e_regwen_q) ||
                src_hit(UseRs2D, Rs2D, e_rd_q, e_regwen_q) ||
                src_hit(UseRs1D, Rs1D, m_rd_q, m_regwen_q) ||
                src_hit(UseRs2D, Rs2D, m_rd_q, m_regwen_q);
`endif
  end

  // Prioritised stall/flush decision: memory wait, redirect, RAW hazard, normal.
  always_comb begin
    redir_s      = PCSelE || redir_pend_q;
    redir_pend_d = 1'b0;
    stall_f_s    = 1'b0;
    stall_d_s    = 1'b0;
    stall_e_s    = 1'b0;
    stall_m_s    = 1'b0;
    flush_d_s    = 1'b0;
    flush_e_s    = 1'b0;
    if (mem_stall_s) begin
      // E is frozen, so a redirect seen now is replayed once E advances.
      stall_f_s    = 1'b1;
      stall_d_s    = 1'b1;
      stall_e_s    = 1'b1;
      stall_m_s    = 1'b1;
      redir_pend_d = redir_s;
    end else if (redir_s) begin
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else if (raw_hit_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      redir_pend_d = 1'b0;
    end
  end

`ifdef HAZARD_FWD_EN
  // E-stage forwarding selects from the shadow M/W destinations.
  always_comb begin
    fwd_a_s = fwd_sel(e_rs1_q);
    fwd_b_s = fwd_sel(e_rs2_q);
  end
`else
  logic unused_s;

  // Without forwarding the register file always supplies operands.
  always_comb begin
    fwd_a_s  = 2'b00;
    fwd_b_s  = 2'b00;
    unused_s = ^{e_rs1_q, e_rs2_q, e_isload_q, w_rd_q, w_regwen_q};
  end
`endif

  // Drive outputs; everything reads zero while reset is held.
  always_comb begin
    if (reset_n) begin
      StallF    = stall_f_s;
      StallD    = stall_d_s;
      StallE    = stall_e_s;
      StallM    = stall_m_s;
      FlushD    = flush_d_s;
      FlushE    = flush_e_s;
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
    end else begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
    StallCnt = stall_cnt_q;
  end

  // Shadow pipeline advance mirrors the real pipeline registers; counter saturates.
  always_comb begin
    if (flush_e_s) begin
      e_rs1_d    = 5'd0;
      e_rs2_d    = 5'd0;
      e_rd_d     = 5'd0;
      e_regwen_d = 1'b0;
      e_isload_d = 1'b0;
    end else if (stall_e_s) begin
      e_rs1_d    = e_rs1_q;
      e_rs2_d    = e_rs2_q;
      e_rd_d     = e_rd_q;
      e_regwen_d = e_regwen_q;
      e_isload_d = e_isload_q;
    end else begin
      e_rs1_d    = Rs1D;
      e_rs2_d    = Rs2D;
      e_rd_d     = RdD;
      e_regwen_d = RegWEnD;
      e_isload_d = IsLoadD;
    end
    if (stall_m_s) begin
      m_rd_d     = m_rd_q;
      m_regwen_d = m_regwen_q;
      w_rd_d     = 5'd0;
      w_regwen_d = 1'b0;
    end else begin
      m_rd_d     = e_rd_q;
      m_regwen_d = e_regwen_q;
      w_rd_d     = m_rd_q;
      w_regwen_d = m_regwen_q;
    end
    if (StallF && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State register: FSM, shadow pipeline, deferred redirect and stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      e_rs1_q      <= 5'd0;
      e_rs2_q      <= 5'd0;
      e_rd_q       <= 5'd0;
      e_regwen_q   <= 1'b0;
      e_isload_q   <= 1'b0;
      m_rd_q       <= 5'd0;
      m_regwen_q   <= 1'b0;
      w_rd_q       <= 5'd0;
      w_regwen_q   <= 1'b0;
      redir_pend_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      e_rs1_q      <= e_rs1_d;
      e_rs2_q      <= e_rs2_d;
      e_rd_q       <= e_rd_d;
      e_regwen_q   <= e_regwen_d;
      e_isload_q   <= e_isload_d;
      m_rd_q       <= m_rd_d;
      m_regwen_q   <= m_regwen_d;
      w_rd_q       <= w_rd_d;
      w_regwen_q   <= w_regwen_d;
      redir_pend_q <= redir_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard controller for the 5-stage RV32I pipeline. Drives stall and clear inputs into the IF/ID and ID/EX pipeline registers, for example the ID/EX `clear` that zeroes the E-stage control bits. Keeps its own shadow scoreboard of destination registers for E, M and W, and produces the E-stage forwarding selects. A small state machine freezes the pipeline while a data-memory access waits for acknowledge, and counts stall cycles.

## Interface
- No parameters.
- `clk` in 1: pipeline clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `Rs1D`, `Rs2D` in 5 each: D-stage source registers.
- `UseRs1D`, `UseRs2D` in 1 each: the instruction in D reads that source.
- `RdD` in 5: D-stage destination register.
- `RegWEnD` in 1: D-stage writes the register file.
- `IsLoadD` in 1: D-stage is a load.
- `PCSelE` in 1: taken branch or jump resolved in E (redirect).
- `MemReqM` in 1: M-stage data-memory access is active.
- `MemAckM` in 1: data memory completes the access this cycle.
- `StallF`, `StallD` out 1: hold the PC and the IF/ID register.
- `StallE`, `StallM` out 1: hold the ID/EX and EX/MEM registers.
- `FlushD` out 1: clear the IF/ID register.
- `FlushE` out 1: clear the ID/EX register (its `clear` input).
- `ForwardAE`, `ForwardBE` out 2: 00 register file, 10 M-stage ALU result, 01 W-stage result.
- `StallCnt` out 16: saturating count of cycles with `StallF`=1.

## Operation
- **Shadow pipeline.** The block holds internal registers E{rs1,rs2,rd,regwen,isload}, M{rd,regwen} and W{rd,regwen}. They advance exactly as the real pipeline registers do.
  - E loads the D fields unless `StallE`. If `FlushE`, E loads a bubble (all zero).
  - M loads E unless `StallM`.
  - W loads M if M advances, otherwise W loads a bubble.
- **FSM states.**
  - RUN to MEM_WAIT when `MemReqM`=1 and `MemAckM`=0.
  - MEM_WAIT to RUN on `MemAckM`=1.
  - MEM_WAIT to MEM_WAIT otherwise.
- **MEM_WAIT, and the RUN cycle that detects a miss.** `StallF`, `StallD`, `StallE` and `StallM` are all 1. All flushes are 0. A pending `PCSelE` is deferred until E advances.
- **Redirect (RUN, `PCSelE`=1, no memory wait).** `FlushD`=`FlushE`=1. Stalls are 0. Redirect takes priority over load-use.
- **Load-use (RUN, no redirect).** Condition: E.isload, E.regwen, E.rd≠0, and E.rd matches a used D source. Response: `StallF`=`StallD`=1 and `FlushE`=1 for exactly one cycle.
- **Forwarding, per E source.** Source is never x0.
  - M match (M.regwen, M.rd=E.rs) selects 10.
  - Otherwise W match selects 01.
  - Otherwise 00.
  - M has priority over W.
- **Priority.** Memory wait, then redirect, then load-use, then normal.
- `StallCnt` increments on every edge where `StallF`=1. It saturates at 16'hFFFF.

## Timing
- All stall, flush and forward outputs are combinational from the current state, shadow registers and inputs. They take effect at the next rising edge.
- The FSM, shadow pipeline and `StallCnt` update on the rising edge.
- **Reset.** `reset_n`=0 forces RUN, all shadow registers to bubble and `StallCnt`=0. All outputs read 0 for as long as reset is held, including reset asserted mid-MEM_WAIT. No deferred redirect survives reset.
- **Load-use latency.** One bubble. On the following cycle, E holds the bubble and the consumer stays in D. With forwarding, the load then reaches W and forwards 01.
- **Ack in the detect cycle.** `MemReqM` with `MemAckM`=1 in the same cycle causes no stall.

## Configuration
- Macro `HAZARD_FWD_EN`.
- **Defined:** forwarding operates as described.
- **Undefined:**
  - `ForwardAE` and `ForwardBE` are tied to 00.
  - Any used D source matching a nonzero rd in E or M with regwen stalls like load-use (`StallF`/`StallD`=1, `FlushE`=1) until the producer reaches W.
  - The register file is write-first, so a W match needs no stall.

## Test plan
- **Back-to-back ALU dependency.** `add` x5, then `sub` using x5. Expect `ForwardAE`=10 in the consumer's E cycle. With the macro off, expect 2 stall cycles and `StallCnt`=2.
- **Load-use.** `lw` x6, then `add` using x6. Expect exactly one cycle of `StallF`=`StallD`=`FlushE`=1, then `ForwardAE`=01.
- **Redirect.** `PCSelE`=1 for one cycle. Expect `FlushD`=`FlushE`=1 that cycle only, no stall, and the shadow E bubble on the next cycle.
- **Memory wait.** `MemReqM`=1 with `MemAckM` low for 3 cycles. Expect all four stalls high for 3 cycles, release on the ack edge, and `StallCnt`=3.
- **Reset during MEM_WAIT.** Pull `reset_n` low while in MEM_WAIT. Expect all outputs 0 immediately and `StallCnt`=0. After release, the FSM is in RUN with no forwarding from stale shadow entries.
- **Writes to x0.** A producer writing x0 followed by a consumer reading x0. Expect forward 00 and no stall.
